// File: rtl/housekeeping_spi_slave_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : housekeeping_spi_slave_pkg
// Purpose  : Shared definitions for the housekeeping SPI slave: register
//            addresses, SPI command codes, register reset values and the
//            transaction state enum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package housekeeping_spi_slave_pkg;

  // SPI command codes (first byte of a transaction)
  localparam logic [7:0] CMD_WRITE      = 8'h80;
  localparam logic [7:0] CMD_READ       = 8'h40;
  localparam logic [7:0] CMD_READ_WRITE = 8'hC0;

  // Register map
  localparam logic [7:0] ADDR_STATUS    = 8'h00;
  localparam logic [7:0] ADDR_MFGR_HI   = 8'h01;
  localparam logic [7:0] ADDR_MFGR_LO   = 8'h02;
  localparam logic [7:0] ADDR_PROD      = 8'h03;
  localparam logic [7:0] ADDR_MASK_3    = 8'h04;
  localparam logic [7:0] ADDR_MASK_2    = 8'h05;
  localparam logic [7:0] ADDR_MASK_1    = 8'h06;
  localparam logic [7:0] ADDR_MASK_0    = 8'h07;
  localparam logic [7:0] ADDR_PLL_CTRL  = 8'h08;
  localparam logic [7:0] ADDR_PLL_BYP   = 8'h09;
  localparam logic [7:0] ADDR_IRQ       = 8'h0A;
  localparam logic [7:0] ADDR_EXT_RST   = 8'h0B;
  localparam logic [7:0] ADDR_TRAP      = 8'h0C;
  localparam logic [7:0] ADDR_TRIM_0    = 8'h0D;
  localparam logic [7:0] ADDR_TRIM_1    = 8'h0E;
  localparam logic [7:0] ADDR_TRIM_2    = 8'h0F;
  localparam logic [7:0] ADDR_TRIM_3    = 8'h10;
  localparam logic [7:0] ADDR_PLL_DIV   = 8'h11;
  localparam logic [7:0] ADDR_PLL_FB    = 8'h12;

  // Register reset values
  localparam logic        RST_PLL_ENA     = 1'b0;
  localparam logic        RST_PLL_DCO_ENA = 1'b1;
  localparam logic        RST_PLL_BYPASS  = 1'b1;
  localparam logic        RST_IRQ         = 1'b0;
  localparam logic        RST_EXT_RESET   = 1'b0;
  localparam logic [25:0] RST_PLL_TRIM    = 26'h3FFEFFF;
  localparam logic [2:0]  RST_PLL_DIV     = 3'd2;
  localparam logic [2:0]  RST_PLL_SEL     = 3'd2;
  localparam logic [4:0]  RST_PLL_FB_DIV  = 5'd4;

  // Transaction state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMAND = 2'd1,
    ST_ADDRESS = 2'd2,
    ST_DATA    = 2'd3
  } spi_state_t;

endpackage : housekeeping_spi_slave_pkg
`default_nettype wire

// File: rtl/housekeeping_spi_slave_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : spi_slave_sync
// Purpose  : Brings the asynchronous SPI pins into the system clock domain
//            with 2-flop synchronizers and derives SCK-rise / CSB-fall pulses.
// Ports    : i_clock, i_resetb   - system clock, async active-low reset
//            i_sck, i_csb, i_sdi - raw SPI pins
//            o_sck_rise          - one-cycle pulse on synchronized SCK rise
//            o_csb_fall          - one-cycle pulse on synchronized CSB fall
//            o_csb, o_sdi        - synchronized CSB / SDI levels
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module spi_slave_sync (
  input  logic i_clock,
  input  logic i_resetb,
  input  logic i_sck,
  input  logic i_csb,
  input  logic i_sdi,
  output logic o_sck_rise,
  output logic o_csb_fall,
  output logic o_csb,
  output logic o_sdi
);

  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_csb_meta, r_csb_sync, r_csb_prev;
  logic r_sdi_meta, r_sdi_sync;

  // The CSB chain resets to "selected" (0): if CSB is already low when reset
  // releases no falling edge is seen, so the slave waits for a fresh select.
  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_csb_meta <= 1'b0;
      r_csb_sync <= 1'b0;
      r_csb_prev <= 1'b0;
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sck_meta <= i_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_csb_meta <= i_csb;
      r_csb_sync <= r_csb_meta;
      r_csb_prev <= r_csb_sync;
      r_sdi_meta <= i_sdi;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  assign o_sck_rise = r_sck_sync & ~r_sck_prev;
  assign o_csb_fall = r_csb_prev & ~r_csb_sync;
  assign o_csb      = r_csb_sync;
  assign o_sdi      = r_sdi_sync;

endmodule : spi_slave_sync
`default_nettype wire

// File: rtl/housekeeping_spi_slave.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : housekeeping_spi_slave
// Purpose  : SPI mode-0 slave giving access to a small housekeeping register
//            file (IDs, PLL controls, IRQ, external reset, trap status).
//            Transaction: CSB low, command byte, address byte, data bytes
//            with auto-incrementing address until CSB rises.
// Ports    : clock, resetb       - system clock, async active-low reset
//            SCK, CSB, SDI, SDO  - SPI pins (asynchronous to clock)
//            sdo_enb             - SDO output enable, active low
//            trap                - CPU trap status (read-only register)
//            pll_*, irq, ext_reset - register-driven control outputs
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module housekeeping_spi_slave
  import housekeeping_spi_slave_pkg::*;
#(
  parameter logic [11:0] MFGR_ID  = 12'h456,
  parameter logic [7:0]  PROD_ID  = 8'h11,
  parameter logic [31:0] MASK_REV = 32'h0
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        SCK,
  input  logic        CSB,
  input  logic        SDI,
  output logic        SDO,
  output logic        sdo_enb,
  input  logic        trap,
  output logic        pll_ena,
  output logic        pll_dco_ena,
  output logic        pll_bypass,
  output logic        irq,
  output logic        ext_reset,
  output logic [25:0] pll_trim,
  output logic [2:0]  pll_div,
  output logic [2:0]  pll_sel,
  output logic [4:0]  pll_fb_div
);

  logic w_sck_rise, w_csb_fall, w_csb, w_sdi;

  spi_slave_sync u_sync (
    .i_clock    (clock),
    .i_resetb   (resetb),
    .i_sck      (SCK),
    .i_csb      (CSB),
    .i_sdi      (SDI),
    .o_sck_rise (w_sck_rise),
    .o_csb_fall (w_csb_fall),
    .o_csb      (w_csb),
    .o_sdi      (w_sdi)
  );

  spi_state_t  r_state;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift;      // bits already received of the current byte
  logic [7:0]  r_addr;
  logic [7:0]  r_out;        // read data being shifted out, MSB at [7]
  logic        r_wr_mode;
  logic        r_rd_mode;
  logic        r_sdo;
  logic        r_sdo_enb;

  logic        r_pll_ena;
  logic        r_pll_dco_ena;
  logic        r_pll_bypass;
  logic        r_irq;
  logic        r_ext_reset;
  logic [25:0] r_pll_trim;
  logic [2:0]  r_pll_div;
  logic [2:0]  r_pll_sel;
  logic [4:0]  r_pll_fb_div;

  logic [7:0]  w_shift_next; // full byte as it stands after this SCK rise
  logic        w_byte_done;
  logic [7:0]  w_rd_addr;
  logic [7:0]  w_rd_data;

  assign w_shift_next = {r_shift, w_sdi};
  assign w_byte_done  = w_sck_rise && (r_bit_cnt == 3'd7);

  // Read data is only consumed at byte boundaries: right after the address
  // byte (the address just received) or after a data byte (the next address).
  always_comb begin
    w_rd_addr = (r_state == ST_ADDRESS) ? w_shift_next : (r_addr + 8'd1);
    w_rd_data = 8'h00;
    case (w_rd_addr)
      ADDR_STATUS:   w_rd_data = 8'h00;
      ADDR_MFGR_HI:  w_rd_data = {4'b0, MFGR_ID[11:8]};
      ADDR_MFGR_LO:  w_rd_data = MFGR_ID[7:0];
      ADDR_PROD:     w_rd_data = PROD_ID;
      ADDR_MASK_3:   w_rd_data = MASK_REV[31:24];
      ADDR_MASK_2:   w_rd_data = MASK_REV[23:16];
      ADDR_MASK_1:   w_rd_data = MASK_REV[15:8];
      ADDR_MASK_0:   w_rd_data = MASK_REV[7:0];
      ADDR_PLL_CTRL: w_rd_data = {6'b0, r_pll_dco_ena, r_pll_ena};
      ADDR_PLL_BYP:  w_rd_data = {7'b0, r_pll_bypass};
      ADDR_IRQ:      w_rd_data = {7'b0, r_irq};
      ADDR_EXT_RST:  w_rd_data = {7'b0, r_ext_reset};
      ADDR_TRAP:     w_rd_data = {7'b0, trap};
      ADDR_TRIM_0:   w_rd_data = r_pll_trim[7:0];
      ADDR_TRIM_1:   w_rd_data = r_pll_trim[15:8];
      ADDR_TRIM_2:   w_rd_data = r_pll_trim[23:16];
      ADDR_TRIM_3:   w_rd_data = {6'b0, r_pll_trim[25:24]};
      ADDR_PLL_DIV:  w_rd_data = {2'b0, r_pll_sel, r_pll_div};
      ADDR_PLL_FB:   w_rd_data = {3'b0, r_pll_fb_div};
      default:       w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 7'd0;
      r_addr        <= 8'd0;
      r_out         <= 8'd0;
      r_wr_mode     <= 1'b0;
      r_rd_mode     <= 1'b0;
      r_sdo         <= 1'b0;
      r_sdo_enb     <= 1'b1;
      r_pll_ena     <= RST_PLL_ENA;
      r_pll_dco_ena <= RST_PLL_DCO_ENA;
      r_pll_bypass  <= RST_PLL_BYPASS;
      r_irq         <= RST_IRQ;
      r_ext_reset   <= RST_EXT_RESET;
      r_pll_trim    <= RST_PLL_TRIM;
      r_pll_div     <= RST_PLL_DIV;
      r_pll_sel     <= RST_PLL_SEL;
      r_pll_fb_div  <= RST_PLL_FB_DIV;
    end else if (w_csb) begin
      // Deselected: any partial byte is dropped and SDO is released.
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_wr_mode <= 1'b0;
      r_rd_mode <= 1'b0;
      r_sdo     <= 1'b0;
      r_sdo_enb <= 1'b1;
    end else begin
      if (w_sck_rise && (r_state != ST_IDLE)) begin
        r_shift   <= w_shift_next[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_csb_fall) begin
            r_state   <= ST_COMMAND;
            r_bit_cnt <= 3'd0;
          end
        end
        ST_COMMAND: begin
          if (w_byte_done) begin
            // Unknown commands leave both modes off, so the rest of the
            // transaction is clocked through with no effect.
            r_wr_mode <= (w_shift_next == CMD_WRITE) || (w_shift_next == CMD_READ_WRITE);
            r_rd_mode <= (w_shift_next == CMD_READ)  || (w_shift_next == CMD_READ_WRITE);
            r_state   <= ST_ADDRESS;
          end
        end
        ST_ADDRESS: begin
          if (w_byte_done) begin
            r_addr  <= w_shift_next;
            r_state <= ST_DATA;
            if (r_rd_mode) begin
              r_out     <= w_rd_data;
              r_sdo     <= w_rd_data[7];
              r_sdo_enb <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            if (r_wr_mode) begin
              case (r_addr)
                ADDR_PLL_CTRL: {r_pll_dco_ena, r_pll_ena} <= w_shift_next[1:0];
                ADDR_PLL_BYP:  r_pll_bypass             <= w_shift_next[0];
                ADDR_IRQ:      r_irq                    <= w_shift_next[0];
                ADDR_EXT_RST:  r_ext_reset              <= w_shift_next[0];
                ADDR_TRIM_0:   r_pll_trim[7:0]          <= w_shift_next;
                ADDR_TRIM_1:   r_pll_trim[15:8]         <= w_shift_next;
                ADDR_TRIM_2:   r_pll_trim[23:16]        <= w_shift_next;
                ADDR_TRIM_3:   r_pll_trim[25:24]        <= w_shift_next[1:0];
                ADDR_PLL_DIV:  {r_pll_sel, r_pll_div}   <= w_shift_next[5:0];
                ADDR_PLL_FB:   r_pll_fb_div             <= w_shift_next[4:0];
                default: ;
              endcase
            end
            r_addr <= r_addr + 8'd1;
            if (r_rd_mode) begin
              r_out <= w_rd_data;
              r_sdo <= w_rd_data[7];
            end
          end else if (w_sck_rise && r_rd_mode) begin
            r_out <= {r_out[6:0], 1'b0};
            r_sdo <= r_out[6];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SDO         = r_sdo;
  assign sdo_enb     = r_sdo_enb;
  assign pll_ena     = r_pll_ena;
  assign pll_dco_ena = r_pll_dco_ena;
  assign pll_bypass  = r_pll_bypass;
  assign irq         = r_irq;
  assign ext_reset   = r_ext_reset;
  assign pll_trim    = r_pll_trim;
  assign pll_div     = r_pll_div;
  assign pll_sel     = r_pll_sel;
  assign pll_fb_div  = r_pll_fb_div;

endmodule : housekeeping_spi_slave
`default_nettype wire

// File: tb/tb_housekeeping_spi_slave.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_housekeeping_spi_slave
// Purpose  : Self-checking bench for housekeeping_spi_slave. Drives SPI mode-0
//            transactions (SCK period 80 ns, clock period 10 ns) and compares
//            readback data and control outputs against hand-computed values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_housekeeping_spi_slave;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        SCK = 1'b0;
  logic        CSB = 1'b1;
  logic        SDI = 1'b0;
  logic        SDO;
  logic        sdo_enb;
  logic        trap = 1'b0;
  logic        pll_ena, pll_dco_ena, pll_bypass, irq, ext_reset;
  logic [25:0] pll_trim;
  logic [2:0]  pll_div, pll_sel;
  logic [4:0]  pll_fb_div;

  int n_checks = 0;
  int n_errors = 0;

  housekeeping_spi_slave dut (
    .clock       (clock),
    .resetb      (resetb),
    .SCK         (SCK),
    .CSB         (CSB),
    .SDI         (SDI),
    .SDO         (SDO),
    .sdo_enb     (sdo_enb),
    .trap        (trap),
    .pll_ena     (pll_ena),
    .pll_dco_ena (pll_dco_ena),
    .pll_bypass  (pll_bypass),
    .irq         (irq),
    .ext_reset   (ext_reset),
    .pll_trim    (pll_trim),
    .pll_div     (pll_div),
    .pll_sel     (pll_sel),
    .pll_fb_div  (pll_fb_div)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Shifts nbits of tx (MSB first); SDO and sdo_enb are sampled at each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic enb_at_msb);
    rx = 8'h00;
    enb_at_msb = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      SDI = tx[i];
      #40;
      SCK = 1'b1;
      rx[i] = SDO;
      if (i == 7) enb_at_msb = sdo_enb;
      #40;
      SCK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic e;
    spi_bits(tx, 8, rx, e);
  endtask

  task automatic txn_start();
    @(negedge clock);
    CSB = 1'b0;
    #80;
  endtask

  task automatic txn_end();
    #80;
    CSB = 1'b1;
    #200;
  endtask

  task automatic read1(input logic [7:0] addr, output logic [7:0] rd);
    logic [7:0] d;
    txn_start();
    spi_byte(8'h40, d);
    spi_byte(addr, d);
    spi_byte(8'h00, rd);
    txn_end();
  endtask

  task automatic write1(input logic [7:0] addr, input logic [7:0] wd);
    logic [7:0] d;
    txn_start();
    spi_byte(8'h80, d);
    spi_byte(addr, d);
    spi_byte(wd, d);
    txn_end();
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } wvec_t;

  wvec_t      wtab [11];
  logic [7:0] exp_stream [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd, d;
    logic       e;

    exp_stream[0]  = 8'h00; exp_stream[1]  = 8'h04; exp_stream[2]  = 8'h56;
    exp_stream[3]  = 8'h11; exp_stream[4]  = 8'h00; exp_stream[5]  = 8'h00;
    exp_stream[6]  = 8'h00; exp_stream[7]  = 8'h00; exp_stream[8]  = 8'h02;
    exp_stream[9]  = 8'h01; exp_stream[10] = 8'h00; exp_stream[11] = 8'h00;
    exp_stream[12] = 8'h00; exp_stream[13] = 8'hFF; exp_stream[14] = 8'hEF;
    exp_stream[15] = 8'hFF; exp_stream[16] = 8'h03; exp_stream[17] = 8'h12;
    exp_stream[18] = 8'h04;

    // {address, write data, expected readback}
    wtab[0]  = '{8'h08, 8'h03, 8'h03};
    wtab[1]  = '{8'h08, 8'hFC, 8'h00};
    wtab[2]  = '{8'h00, 8'hAA, 8'h00};
    wtab[3]  = '{8'h03, 8'h55, 8'h11};
    wtab[4]  = '{8'h06, 8'hFF, 8'h00};
    wtab[5]  = '{8'h11, 8'hFF, 8'h3F};
    wtab[6]  = '{8'h12, 8'hE3, 8'h03};
    wtab[7]  = '{8'h0A, 8'h01, 8'h01};
    wtab[8]  = '{8'h20, 8'h7F, 8'h00};
    wtab[9]  = '{8'h10, 8'hFE, 8'h02};
    wtab[10] = '{8'h0C, 8'hFF, 8'h00};

    // Reset state
    #23;
    chk("reset_sdo", {31'b0, SDO}, 32'h0);
    chk("reset_sdo_enb", {31'b0, sdo_enb}, 32'h1);
    #40;
    resetb = 1'b1;
    #100;
    chk("reset_outs", {27'b0, pll_ena, pll_dco_ena, pll_bypass, irq, ext_reset}, 32'h0C);
    chk("reset_trim", {6'b0, pll_trim}, 32'h3FFEFFF);
    chk("reset_div", {21'b0, pll_sel, pll_div, pll_fb_div}, {21'b0, 3'd2, 3'd2, 5'd4});

    // Single read of the product ID
    read1(8'h03, rd);
    chk("read_prod_id", {24'b0, rd}, 32'h11);

    // Streamed read of the full map, checking sdo_enb framing on the way
    txn_start();
    spi_bits(8'h40, 8, d, e);
    chk("enb_in_cmd", {31'b0, e}, 32'h1);
    spi_byte(8'h00, d);
    for (int i = 0; i < 19; i++) begin
      spi_bits(8'h00, 8, rd, e);
      chk($sformatf("stream_rd[%0d]", i), {24'b0, rd}, {24'b0, exp_stream[i]});
      if (i == 0) chk("enb_in_read", {31'b0, e}, 32'h0);
    end
    txn_end();
    chk("enb_after_csb", {31'b0, sdo_enb}, 32'h1);

    // ext_reset set then cleared
    write1(8'h0B, 8'h01);
    chk("ext_reset_set", {31'b0, ext_reset}, 32'h1);
    write1(8'h0B, 8'h00);
    chk("ext_reset_clr", {31'b0, ext_reset}, 32'h0);
    read1(8'h0B, rd);
    chk("ext_reset_rd", {24'b0, rd}, 32'h00);

    // Stream write of pll_trim, then read-then-write of the feedback divider
    txn_start();
    spi_byte(8'h80, d);
    spi_byte(8'h0D, d);
    spi_byte(8'h11, d);
    spi_byte(8'h22, d);
    spi_byte(8'h33, d);
    spi_byte(8'h01, d);
    txn_end();
    chk("trim_out", {6'b0, pll_trim}, 32'h1332211);
    read1(8'h0D, rd); chk("trim_rd0", {24'b0, rd}, 32'h11);
    read1(8'h0F, rd); chk("trim_rd2", {24'b0, rd}, 32'h33);
    read1(8'h10, rd); chk("trim_rd3", {24'b0, rd}, 32'h01);
    txn_start();
    spi_byte(8'hC0, d);
    spi_byte(8'h12, d);
    spi_byte(8'h1F, rd);
    txn_end();
    chk("rmw_old", {24'b0, rd}, 32'h04);
    chk("rmw_fb_div", {27'b0, pll_fb_div}, 32'h1F);

    // Partial data byte to the IRQ register is discarded
    txn_start();
    spi_byte(8'h80, d);
    spi_byte(8'h0A, d);
    spi_bits(8'hFF, 4, d, e);
    txn_end();
    chk("partial_irq", {31'b0, irq}, 32'h0);
    read1(8'h02, rd);
    chk("after_partial_rd", {24'b0, rd}, 32'h56);

    // Clear bypass, then abort a write of 0 to it with a reset pulse
    write1(8'h09, 8'h00);
    chk("bypass_clr", {31'b0, pll_bypass}, 32'h0);
    txn_start();
    spi_byte(8'h80, d);
    spi_byte(8'h09, d);
    spi_bits(8'h00, 4, d, e);
    resetb = 1'b0;
    #20;
    chk("rst_mid_sdo_enb", {31'b0, sdo_enb}, 32'h1);
    resetb = 1'b1;
    #20;
    // Rest of the bits plus a full write while CSB never went high
    for (int i = 0; i < 4; i++) begin
      SDI = 1'b0; #40; SCK = 1'b1; #40; SCK = 1'b0;
    end
    spi_byte(8'h80, d);
    spi_byte(8'h09, d);
    spi_byte(8'h00, d);
    txn_end();
    chk("rst_mid_bypass", {31'b0, pll_bypass}, 32'h1);
    read1(8'h09, rd);
    chk("rst_mid_rd", {24'b0, rd}, 32'h01);
    chk("rst_mid_fb_div", {27'b0, pll_fb_div}, 32'h04);

    // Table of write/readback pairs
    for (int i = 0; i < 11; i++) begin
      write1(wtab[i].addr, wtab[i].wdata);
      read1(wtab[i].addr, rd);
      chk($sformatf("wtab[%0d]@%02h", i, wtab[i].addr), {24'b0, rd}, {24'b0, wtab[i].exp_rd});
    end
    chk("tab_outs", {27'b0, pll_ena, pll_dco_ena, pll_bypass, irq, ext_reset}, 32'h06);
    chk("tab_trim", {6'b0, pll_trim}, 32'h2FFEFFF);
    chk("tab_div", {21'b0, pll_sel, pll_div, pll_fb_div}, {21'b0, 3'd7, 3'd7, 5'd3});

    // Live trap readback
    trap = 1'b1;
    read1(8'h0C, rd);
    chk("trap_rd", {24'b0, rd}, 32'h01);

    // Unknown command leaves the target untouched and SDO released
    txn_start();
    spi_byte(8'h55, d);
    spi_byte(8'h0A, d);
    spi_bits(8'h00, 8, rd, e);
    txn_end();
    chk("badcmd_enb", {31'b0, e}, 32'h1);
    chk("badcmd_irq", {31'b0, irq}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_housekeeping_spi_slave
`default_nettype wire
